// File: rtl/data_memory_sequencer_pkg.sv
// Shared types and constants for the data memory sequencer: request modes,
// RV32I load/store funct3 encodings, sequencer states and a lane extender.
package JZJCoreFTypes;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10
  } MemoryMode_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD_WAIT = 2'b01,
    RMW_WRITE = 2'b10
  } SeqState_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Widen a byte (lane[7:0]) or halfword lane to 32 bits, sign or zero filled.
  function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                              input logic        is_half,
                                              input logic        is_signed);
    logic [31:0] result;
    if (is_half) begin
      result = {{16{is_signed & lane[15]}}, lane};
    end else begin
      result = {{24{is_signed & lane[7]}}, lane[7:0]};
    end
    return result;
  endfunction

endpackage

// File: rtl/data_memory_sequencer_byte_lane_unit.sv
// Byte lane unit: extracts and extends the addressed lane of a RAM word for
// loads, and merges a byte/halfword of store data into a RAM word for
// read-modify-write stores.
module byte_lane_unit
  import JZJCoreFTypes::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] read_word,
  input  logic [15:0] store_data,
  output logic [31:0] load_result,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;

  // Pick the addressed byte and halfword out of the RAM word
  always_comb begin
    byte_lane_s = 8'h00;
    case (byte_offset)
      2'b00:   byte_lane_s = read_word[7:0];
      2'b01:   byte_lane_s = read_word[15:8];
      2'b10:   byte_lane_s = read_word[23:16];
      2'b11:   byte_lane_s = read_word[31:24];
      default: byte_lane_s = read_word[7:0];
    endcase
    if (byte_offset[1]) begin
      half_lane_s = read_word[31:16];
    end else begin
      half_lane_s = read_word[15:0];
    end
  end

  // Format the load result with sign or zero extension
  always_comb begin
    load_result = read_word;
    case (funct3)
      F3_B:    load_result = extend_lane({8'h00, byte_lane_s}, 1'b0, 1'b1);
      F3_BU:   load_result = extend_lane({8'h00, byte_lane_s}, 1'b0, 1'b0);
      F3_H:    load_result = extend_lane(half_lane_s, 1'b1, 1'b1);
      F3_HU:   load_result = extend_lane(half_lane_s, 1'b1, 1'b0);
      F3_W:    load_result = read_word;
      default: load_result = read_word;
    endcase
  end

  // Replace the addressed lane of the old word, preserving the other lanes
  always_comb begin
    store_word = read_word;
    case (funct3)
      F3_B: begin
        case (byte_offset)
          2'b00:   store_word[7:0]   = store_data[7:0];
          2'b01:   store_word[15:8]  = store_data[7:0];
          2'b10:   store_word[23:16] = store_data[7:0];
          2'b11:   store_word[31:24] = store_data[7:0];
          default: store_word[7:0]   = store_data[7:0];
        endcase
      end
      F3_H: begin
        if (byte_offset[1]) begin
          store_word[31:16] = store_data;
        end else begin
          store_word[15:0] = store_data;
        end
      end
      default: store_word = read_word;
    endcase
  end

endmodule

// File: rtl/data_memory_sequencer.sv
// Data memory sequencer: runs RV32I loads and stores against a word-wide
// synchronous RAM with one cycle of read latency. Word stores complete in the
// request cycle; byte/half stores read the word and write the merged word in
// a second cycle. Loads return a formatted result one cycle after the read.
module data_memory_sequencer
  import JZJCoreFTypes::*;
#(
  parameter int RAM_ADDR_WIDTH = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  MemoryMode_t               memoryMode,
  input  logic [2:0]                funct3,
  input  logic [31:0]               address,
  input  logic [31:0]               storeData,
  output logic [31:0]               loadData,
  output logic                      loadValid,
  output logic                      busy,
  output logic                      memoryUnalignedAccess,
  output logic                      memoryBadFunct3,
  output logic [RAM_ADDR_WIDTH-1:0] ramAddress,
  output logic                      ramWriteEnable,
  output logic [31:0]               ramWriteData,
  input  logic [31:0]               ramReadData
);

  SeqState_t                 state_q, state_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                offset_q, offset_d;
  logic [15:0]               store_lo_q, store_lo_d;
  logic [RAM_ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [31:0]               load_data_q, load_data_d;
  logic                      load_valid_q, load_valid_d;
  logic                      busy_q, busy_d;

  logic                      is_load_s, is_store_s;
  logic                      bad_funct3_s, unaligned_s, accept_s;
  logic [RAM_ADDR_WIDTH-1:0] ram_address_s;
  logic                      ram_we_s;
  logic [31:0]               ram_wdata_s;
  logic                      bad_flag_s, unal_flag_s;
  logic [31:0]               lane_load_s, lane_store_s;
  logic                      unused_upper_addr_s;

  // Address bits above the RAM word index wrap and are deliberately dropped
  assign unused_upper_addr_s = ^address[31:RAM_ADDR_WIDTH+2];

  byte_lane_unit u_lanes (
    .funct3      (funct3_q),
    .byte_offset (offset_q),
    .read_word   (ramReadData),
    .store_data  (store_lo_q),
    .load_result (lane_load_s),
    .store_word  (lane_store_s)
  );

  // Validate the live request: bad funct3 first, then alignment for its size
  always_comb begin
    is_load_s    = (memoryMode == LOAD);
    is_store_s   = (memoryMode == STORE);
    bad_funct3_s = 1'b0;
    case (memoryMode)
      LOAD:    bad_funct3_s = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      STORE:   bad_funct3_s = (funct3 >= 3'b011);
      default: bad_funct3_s = 1'b0;
    endcase
    unaligned_s = 1'b0;
    if ((is_load_s || is_store_s) && !bad_funct3_s) begin
      case (funct3[1:0])
        2'b01:   unaligned_s = address[0];
        2'b10:   unaligned_s = (address[1:0] != 2'b00);
        default: unaligned_s = 1'b0;
      endcase
    end else begin
      unaligned_s = 1'b0;
    end
    accept_s = (is_load_s || is_store_s) && !bad_funct3_s && !unaligned_s;
  end

  // Next-state and RAM-side control for the IDLE / LOAD_WAIT / RMW_WRITE sequencer
  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    offset_d      = offset_q;
    store_lo_d    = store_lo_q;
    word_addr_d   = word_addr_q;
    load_data_d   = load_data_q;
    load_valid_d  = 1'b0;
    ram_address_s = word_addr_q;
    ram_we_s      = 1'b0;
    ram_wdata_s   = 32'h0000_0000;
    bad_flag_s    = 1'b0;
    unal_flag_s   = 1'b0;
    case (state_q)
      IDLE: begin
        ram_address_s = address[RAM_ADDR_WIDTH+1:2];
        bad_flag_s    = bad_funct3_s;
        unal_flag_s   = unaligned_s;
        if (accept_s) begin
          funct3_d    = funct3;
          offset_d    = address[1:0];
          store_lo_d  = storeData[15:0];
          word_addr_d = address[RAM_ADDR_WIDTH+1:2];
          if (is_load_s) begin
            state_d = LOAD_WAIT;
          end else if (funct3 == F3_W) begin
            ram_we_s    = 1'b1;
            ram_wdata_s = storeData;
            state_d     = IDLE;
          end else begin
            state_d = RMW_WRITE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_WAIT: begin
        load_data_d  = lane_load_s;
        load_valid_d = 1'b1;
        state_d      = IDLE;
      end
      RMW_WRITE: begin
        ram_we_s    = 1'b1;
        ram_wdata_s = lane_store_s;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Reset overrides the RAM strobe and flags so a pending RMW write never lands
  always_comb begin
    ramAddress = ram_address_s;
    if (reset) begin
      ramWriteEnable        = 1'b0;
      ramWriteData          = 32'h0000_0000;
      memoryBadFunct3       = 1'b0;
      memoryUnalignedAccess = 1'b0;
    end else begin
      ramWriteEnable        = ram_we_s;
      ramWriteData          = ram_wdata_s;
      memoryBadFunct3       = bad_flag_s;
      memoryUnalignedAccess = unal_flag_s;
    end
  end

  assign loadData  = load_data_q;
  assign loadValid = load_valid_q;
  assign busy      = busy_q;

  // Sequencer state, captured request and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      funct3_q     <= 3'b000;
      offset_q     <= 2'b00;
      store_lo_q   <= 16'h0000;
      word_addr_q  <= '0;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      store_lo_q   <= store_lo_d;
      word_addr_q  <= word_addr_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_data_memory_sequencer.sv
// Self-checking bench for data_memory_sequencer: a behavioural RAM, a
// byte-level reference memory model, directed cases and randomized traffic.
module tb_data_memory_sequencer;
  import JZJCoreFTypes::*;

  localparam int AW = 12;

  logic              clock = 1'b0;
  logic              reset;
  MemoryMode_t       memoryMode;
  logic [2:0]        funct3;
  logic [31:0]       address;
  logic [31:0]       storeData;
  logic [31:0]       loadData;
  logic              loadValid;
  logic              busy;
  logic              memoryUnalignedAccess;
  logic              memoryBadFunct3;
  logic [AW-1:0]     ramAddress;
  logic              ramWriteEnable;
  logic [31:0]       ramWriteData;
  logic [31:0]       ramReadData;

  logic [31:0]       mem [0:(1<<AW)-1];
  logic [31:0]       ref_mem [0:(1<<AW)-1];
  logic [31:0]       ref_load;

  int total = 0;
  int bad   = 0;

  logic        o_bad, o_unal, o_we_req, o_valid, o_valid_after;
  logic [31:0] o_wdata_req, o_load;
  int          o_busy;

  data_memory_sequencer #(.RAM_ADDR_WIDTH(AW)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .memoryMode            (memoryMode),
    .funct3                (funct3),
    .address               (address),
    .storeData             (storeData),
    .loadData              (loadData),
    .loadValid             (loadValid),
    .busy                  (busy),
    .memoryUnalignedAccess (memoryUnalignedAccess),
    .memoryBadFunct3       (memoryBadFunct3),
    .ramAddress            (ramAddress),
    .ramWriteEnable        (ramWriteEnable),
    .ramWriteData          (ramWriteData),
    .ramReadData           (ramReadData)
  );

  always #5 clock = ~clock;

  // Word-wide synchronous RAM, one cycle read latency
  always @(posedge clock) begin
    if (ramWriteEnable) mem[ramAddress] <= ramWriteData;
    ramReadData <= mem[ramAddress];
  end

  // ---------------- reference model ----------------
  function automatic logic m_bad(MemoryMode_t m, logic [2:0] f);
    if (m == LOAD)  return !(f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    if (m == STORE) return (f > 3'd2);
    return 1'b0;
  endfunction

  function automatic int m_bytes(logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic m_unal(MemoryMode_t m, logic [2:0] f, logic [31:0] a);
    if (m == NOP || m_bad(m, f)) return 1'b0;
    return (a % m_bytes(f)) != 0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] a);
    logic [31:0] v;
    v = ref_mem[(a / 4) % 4096] >> ((a % 4) * 8);
    if (m_bytes(f) == 1) begin
      v = v & 32'h0000_00FF;
      if (f[2] == 1'b0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (m_bytes(f) == 2) begin
      v = v & 32'h0000_FFFF;
      if (f[2] == 1'b0 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic model_apply(input MemoryMode_t m, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (m == NOP || m_bad(m, f) || m_unal(m, f, a)) return;
    if (m == LOAD) begin
      ref_load = m_load(f, a);
    end else begin
      sh = (a % 4) * 8;
      if (m_bytes(f) == 4) mask = 32'hFFFF_FFFF;
      else mask = ((32'h1 << (8 * m_bytes(f))) - 32'h1) << sh;
      ref_mem[(a / 4) % 4096] = (ref_mem[(a / 4) % 4096] & ~mask) | ((d << sh) & mask);
    end
  endtask

  // ---------------- stimulus driver ----------------
  // Issues one request, holds random junk on the inputs while busy and
  // records what the DUT showed in each phase.
  task automatic access(input MemoryMode_t m, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clock);
    memoryMode = m; funct3 = f; address = a; storeData = d;
    #1;
    o_bad = memoryBadFunct3; o_unal = memoryUnalignedAccess;
    o_we_req = ramWriteEnable; o_wdata_req = ramWriteData;
    @(posedge clock); #1;
    memoryMode = NOP;
    n = 0;
    while (busy === 1'b1 && n < 4) begin
      n++;
      memoryMode = ($urandom_range(0, 1) == 0) ? LOAD : STORE;
      funct3 = F3_W; address = $urandom & 32'hFFFF_C0FC; storeData = $urandom;
      @(posedge clock); #1;
      memoryMode = NOP;
    end
    o_busy = n; o_valid = loadValid; o_load = loadData;
    @(posedge clock); #1;
    o_valid_after = loadValid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; memoryMode = STORE; funct3 = 3'b011; address = 32'h0000_0002; storeData = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    #1;
    if (loadData !== 32'h0) begin bad++; $display("FAIL reset_loadData got=%h exp=0", loadData); end total++;
    if ({loadValid, busy} !== 2'b00) begin bad++; $display("FAIL reset_valid_busy got=%b exp=00", {loadValid, busy}); end total++;
    if (ramWriteEnable !== 1'b0 || ramWriteData !== 32'h0) begin bad++; $display("FAIL reset_ram got we=%b wd=%h exp 0/0", ramWriteEnable, ramWriteData); end total++;
    if ({memoryBadFunct3, memoryUnalignedAccess} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {memoryBadFunct3, memoryUnalignedAccess}); end total++;
    @(negedge clock);
    memoryMode = NOP; reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] d;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      access(STORE, F3_W, (32'(i) * 32'd4) | ($urandom & 32'hFFFF_C000), d);
      model_apply(STORE, F3_W, 32'(i) * 32'd4, d);
      if (o_we_req !== 1'b1 || o_wdata_req !== d) begin bad++; $display("FAIL sw_write got we=%b wd=%h exp 1/%h", o_we_req, o_wdata_req, d); end total++;
      if (o_busy != 0) begin bad++; $display("FAIL sw_busy got=%0d exp=0", o_busy); end total++;
    end
  endtask

  task automatic test_loads();
    logic [2:0]  tf [5] = '{F3_W, F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] ta [5] = '{32'h08, 32'h0B, 32'h0B, 32'h0A, 32'h0A};
    logic [31:0] te [5] = '{32'h8081_8283, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_8081};
    access(STORE, F3_W, 32'h08, 32'h8081_8283); model_apply(STORE, F3_W, 32'h08, 32'h8081_8283);
    for (int i = 0; i < 5; i++) begin
      access(LOAD, tf[i], ta[i], 32'h0); model_apply(LOAD, tf[i], ta[i], 32'h0);
      if (o_load !== te[i]) begin bad++; $display("FAIL load_data[%0d] got=%h exp=%h", i, o_load, te[i]); end total++;
      if (o_busy != 1 || o_valid !== 1'b1 || o_valid_after !== 1'b0) begin bad++; $display("FAIL load_timing[%0d] got busy=%0d v=%b v2=%b exp 1/1/0", i, o_busy, o_valid, o_valid_after); end total++;
    end
  endtask

  task automatic test_sub_stores();
    logic [2:0]  tf [3] = '{F3_B, F3_H, F3_W};
    logic [31:0] ta [3] = '{32'h05, 32'h06, 32'h10};
    logic [31:0] td [3] = '{32'h1234_56AA, 32'h5555_BEEF, 32'hDEAD_BEEF};
    logic [31:0] te [3] = '{32'h1122_AA44, 32'hBEEF_3344, 32'hDEAD_BEEF};
    int          tb [3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      access(STORE, F3_W, ta[i] & 32'hFFFF_FFFC, 32'h1122_3344); model_apply(STORE, F3_W, ta[i] & 32'hFFFF_FFFC, 32'h1122_3344);
      access(STORE, tf[i], ta[i], td[i]); model_apply(STORE, tf[i], ta[i], td[i]);
      if (o_busy != tb[i]) begin bad++; $display("FAIL store_busy[%0d] got=%0d exp=%0d", i, o_busy, tb[i]); end total++;
      access(LOAD, F3_W, ta[i] & 32'hFFFF_FFFC, 32'h0); model_apply(LOAD, F3_W, ta[i] & 32'hFFFF_FFFC, 32'h0);
      if (o_load !== te[i]) begin bad++; $display("FAIL store_result[%0d] got=%h exp=%h", i, o_load, te[i]); end total++;
    end
  endtask

  task automatic test_errors();
    access(LOAD, F3_W, 32'h02, 32'h0);
    if ({o_bad, o_unal} !== 2'b01 || o_busy != 0 || o_valid !== 1'b0) begin bad++; $display("FAIL lw_unaligned got bad=%b unal=%b busy=%0d v=%b exp 0/1/0/0", o_bad, o_unal, o_busy, o_valid); end total++;
    access(STORE, 3'b011, 32'h11, 32'hCAFE_F00D);
    if ({o_bad, o_unal, o_we_req} !== 3'b100 || o_busy != 0) begin bad++; $display("FAIL store_bad_funct3 got bad=%b unal=%b we=%b busy=%0d exp 1/0/0/0", o_bad, o_unal, o_we_req, o_busy); end total++;
    access(STORE, F3_H, 32'h05, 32'h0000_7777);
    if ({o_bad, o_unal} !== 2'b01 || o_busy != 0) begin bad++; $display("FAIL sh_unaligned got bad=%b unal=%b busy=%0d exp 0/1/0", o_bad, o_unal, o_busy); end total++;
    access(LOAD, F3_W, 32'h10, 32'h0); model_apply(LOAD, F3_W, 32'h10, 32'h0);
    if (o_load !== ref_load) begin bad++; $display("FAIL errors_ram_unchanged got=%h exp=%h", o_load, ref_load); end total++;
  endtask

  task automatic test_reset_mid_rmw();
    access(STORE, F3_W, 32'h04, 32'h1122_3344); model_apply(STORE, F3_W, 32'h04, 32'h1122_3344);
    access(LOAD, F3_W, 32'h04, 32'h0); model_apply(LOAD, F3_W, 32'h04, 32'h0);
    @(negedge clock);
    memoryMode = STORE; funct3 = F3_B; address = 32'h05; storeData = 32'h0000_00AA;
    @(posedge clock); #1;
    memoryMode = NOP;
    if (busy !== 1'b1) begin bad++; $display("FAIL rmw_busy got=%b exp=1", busy); end total++;
    reset = 1'b1; #1;
    if (ramWriteEnable !== 1'b0) begin bad++; $display("FAIL rmw_reset_we got=%b exp=0", ramWriteEnable); end total++;
    @(posedge clock); #1;
    reset = 1'b0;
    ref_load = 32'h0;
    if ({busy, loadValid, ramWriteEnable} !== 3'b000 || loadData !== 32'h0) begin bad++; $display("FAIL rmw_reset_outputs got busy=%b v=%b we=%b ld=%h exp 0/0/0/0", busy, loadValid, ramWriteEnable, loadData); end total++;
    access(LOAD, F3_W, 32'h04, 32'h0); model_apply(LOAD, F3_W, 32'h04, 32'h0);
    if (o_load !== 32'h1122_3344) begin bad++; $display("FAIL rmw_reset_ram got=%h exp=11223344", o_load); end total++;
  endtask

  task automatic test_random();
    MemoryMode_t m;
    logic [2:0]  f;
    logic [31:0] a, d;
    logic        eb, eu, legal;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:             m = NOP;
        1, 2, 3, 4, 5: m = LOAD;
        default:       m = STORE;
      endcase
      f = 3'($urandom_range(0, 7));
      a = $urandom & 32'hFFFF_C0FF;
      d = $urandom;
      eb = m_bad(m, f);
      eu = m_unal(m, f, a);
      legal = (m != NOP) && !eb && !eu;
      access(m, f, a, d);
      model_apply(m, f, a, d);
      if ({o_bad, o_unal} !== {eb, eu}) begin bad++; $display("FAIL rnd_flags[%0d] got=%b%b exp=%b%b", i, o_bad, o_unal, eb, eu); end total++;
      if (o_busy != ((legal && (m == LOAD || f != F3_W)) ? 1 : 0)) begin bad++; $display("FAIL rnd_busy[%0d] got=%0d mode=%0d f3=%0d", i, o_busy, m, f); end total++;
      if (o_we_req !== (legal && m == STORE && f == F3_W)) begin bad++; $display("FAIL rnd_we[%0d] got=%b", i, o_we_req); end total++;
      if (o_valid !== (legal && m == LOAD) || o_valid_after !== 1'b0) begin bad++; $display("FAIL rnd_valid[%0d] got=%b%b", i, o_valid, o_valid_after); end total++;
      if (o_load !== ref_load) begin bad++; $display("FAIL rnd_load[%0d] got=%h exp=%h", i, o_load, ref_load); end total++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'h0;
    ref_load = 32'h0;
    memoryMode = NOP; funct3 = 3'b000; address = 32'h0; storeData = 32'h0;
    test_reset();
    test_fill();
    test_loads();
    test_sub_stores();
    test_errors();
    test_reset_mid_rmw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
